sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
Single-clock FIFO with programmable almost-full/almost-empty thresholds, occupancy count, sticky overflow/underflow flags and a synchronous flush. It is the same-domain counterpart of the team's dual-clock FIFO, for buffering inside one clock domain. It generalises that FIFO to arbitrary (non-power-of-two) depth, selectable first-word-fall-through (FWFT) or registered-read mode, and flow-control watermarks.

Parameters:
DATA_WIDTH, 16, width of each stored word.
FIFO_DEPTH, 32, number of entries; any integer >= 2, not restricted to powers of two.
ALMOST_FULL_LEVEL, 28, almost_full asserts when count >= this value; must be in 1..FIFO_DEPTH.
ALMOST_EMPTY_LEVEL, 4, almost_empty asserts when count <= this value; must be in 0..FIFO_DEPTH-1.
FWFT, 1, 1 = head word visible on rd_data whenever not empty; 0 = registered read with one-cycle latency.

Ports:
clk  input  1  single clock; all logic is on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
clear  input  1  synchronous flush; empties the FIFO and clears the sticky flags.
wr_en  input  1  write request.
wr_data  input  DATA_WIDTH  write data.
full  output  1  count == FIFO_DEPTH.
almost_full  output  1  count >= ALMOST_FULL_LEVEL.
rd_en  input  1  read request.
rd_data  output  DATA_WIDTH  read data.
rd_valid  output  1  FWFT=1: equals ~empty. FWFT=0: one-cycle pulse, rd_data valid.
empty  output  1  count == 0.
almost_empty  output  1  count <= ALMOST_EMPTY_LEVEL.
count  output  $clog2(FIFO_DEPTH+1)  current occupancy.
overflow  output  1  sticky; set when a write is rejected.
underflow  output  1  sticky; set when a read is rejected.

Behaviour:
- Reset (reset_n low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - overflow, underflow and rd_valid go to 0.
  - FWFT=0: rd_data goes to 0.
  - Flags follow: empty=1, almost_empty=1 (whenever ALMOST_EMPTY_LEVEL >= 0), full=0, almost_full=0.
  - Memory contents are not reset.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(FIFO_DEPTH) bits wide.
  - Each increments by 1 and wraps from FIFO_DEPTH-1 to 0; no power-of-two rollover is assumed.
- Read acceptance: rd_acc = rd_en & ~empty.
- Write acceptance: wr_acc = wr_en & (~full | rd_acc). A write to a full FIFO is accepted when a read is accepted in the same cycle.
- Count update: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither.
- Flags are combinational decodes of registered count.
- Rejected read on an empty FIFO: no pointer change; underflow set. A write in the same cycle is still accepted.
- Rejected write: wr_en & ~wr_acc sets overflow; memory and wr_ptr are unchanged.
- FWFT=1 read path:
  - rd_data = mem[rd_ptr], combinational.
  - A word written into an empty FIFO appears on rd_data in the cycle after the write, when empty deasserts.
  - rd_acc pops the current head.
- FWFT=0 read path:
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1; otherwise rd_valid <= 0 and rd_data holds.
  - Latency is 1 cycle from rd_en to data.
- clear:
  - Has priority over wr_en and rd_en in the same cycle; both are ignored, and overflow/underflow are not set that cycle.
  - Pointers, count, overflow, underflow and rd_valid go to 0 on the next edge.
- Asynchronous reset mid-operation discards all contents immediately, with no clock needed.
- Sticky flags clear only on reset or clear.

Test Plan:
- Reset, then 0 operations -> empty=1, almost_empty=1, full=0, count=0, rd_valid=0, overflow=underflow=0.
- FIFO_DEPTH=5 (non-power-of-two), FWFT=1: write 0x1..0x5 -> full=1, count=5. Read all -> 0x1..0x5 in order. Write/read 12 more words -> order preserved across two pointer wraps.
- Full FIFO, wr_en=rd_en=1 with wr_data=0xAA -> head popped, 0xAA accepted, count stays 5, overflow=0. Next cycle wr_en alone -> rejected, overflow=1 and stays 1.
- Empty FIFO, rd_en=wr_en=1 with wr_data=0x33 -> underflow=1, count=1. FWFT=1: rd_data=0x33 next cycle.
- FWFT=0, DEPTH=32, AF=28, AE=4: write 28 words -> almost_full asserts when count reaches 28, almost_empty deasserts when count reaches 5. rd_en for 1 cycle -> rd_valid pulses one cycle later with the first word.
- 10 words stored, overflow=1; assert clear with wr_en=rd_en=1 -> next cycle count=0, empty=1, overflow=0, underflow=0. Asynchronous reset_n pulse mid-burst -> flags return to reset values before the next clk edge.

Source files
------------

// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if: write, read and status bundle for sync_fifo_flags.
interface sync_fifo_flags_if #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 32
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    logic                  clear;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  almost_full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;
    modport master (
        output clear, wr_en, wr_data, rd_en,
        input  full, almost_full, rd_data, rd_valid, empty, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  clear, wr_en, wr_data, rd_en,
        output full, almost_full, rd_data, rd_valid, empty, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO of any depth with watermarks, sticky error flags,
// synchronous flush and selectable first-word-fall-through or registered read.
module sync_fifo_flags #(
    parameter int DATA_WIDTH         = 16,
    parameter int FIFO_DEPTH         = 32,
    parameter int ALMOST_FULL_LEVEL  = 28,
    parameter int ALMOST_EMPTY_LEVEL = 4,
    parameter int FWFT               = 1
) (
    input logic               clk,
    input logic               reset_n,
    sync_fifo_flags_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  empty, full, rd_acc, wr_acc, overflow, underflow;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty  = count == '0;
    assign full   = count == CW'(FIFO_DEPTH);
    assign rd_acc = bus.rd_en & ~empty & ~bus.clear;
    assign wr_acc = bus.wr_en & (~full | rd_acc) & ~bus.clear;

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = count >= CW'(ALMOST_FULL_LEVEL);
    assign bus.almost_empty = count <= CW'(ALMOST_EMPTY_LEVEL);
    assign bus.count        = count;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

    always_ff @(posedge clk)
        if (wr_acc) mem[wr_ptr] <= bus.wr_data;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= bump(wr_ptr);
            if (rd_acc) rd_ptr <= bump(rd_ptr);
            count     <= count + CW'(wr_acc) - CW'(rd_acc);
            overflow  <= overflow | (bus.wr_en & ~wr_acc);
            underflow <= underflow | (bus.rd_en & empty);
        end

    if (FWFT != 0) begin : g_fwft
        assign bus.rd_data  = mem[rd_ptr];
        assign bus.rd_valid = ~empty;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] rd_q;
        logic                  valid_q;
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                rd_q    <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_acc;
                if (rd_acc) rd_q <= mem[rd_ptr];
            end
        assign bus.rd_data  = rd_q;
        assign bus.rd_valid = valid_q;
    end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed checks on a depth-5 FWFT instance and a depth-32 registered-read instance.
module tb_sync_fifo_flags;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sync_fifo_flags_if #(.DATA_WIDTH(16), .FIFO_DEPTH(5))  a ();
    sync_fifo_flags_if #(.DATA_WIDTH(16), .FIFO_DEPTH(32)) b ();

    sync_fifo_flags #(.DATA_WIDTH(16), .FIFO_DEPTH(5), .ALMOST_FULL_LEVEL(4),
                      .ALMOST_EMPTY_LEVEL(1), .FWFT(1))
        u_a (.clk(clk), .reset_n(reset_n), .bus(a));
    sync_fifo_flags #(.DATA_WIDTH(16), .FIFO_DEPTH(32), .ALMOST_FULL_LEVEL(28),
                      .ALMOST_EMPTY_LEVEL(4), .FWFT(0))
        u_b (.clk(clk), .reset_n(reset_n), .bus(b));

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        tests++; if ({a.empty, a.almost_empty, a.full, a.almost_full, a.rd_valid, a.overflow, a.underflow} !== 7'b1100000) begin fails++; $display("FAIL reset_flags_a got %b exp 1100000", {a.empty, a.almost_empty, a.full, a.almost_full, a.rd_valid, a.overflow, a.underflow}); end
        tests++; if (a.count !== 3'd0) begin fails++; $display("FAIL reset_count_a got %0d exp 0", a.count); end
        tests++; if ({b.empty, b.almost_empty, b.full, b.almost_full, b.rd_valid, b.overflow, b.underflow} !== 7'b1100000) begin fails++; $display("FAIL reset_flags_b got %b exp 1100000", {b.empty, b.almost_empty, b.full, b.almost_full, b.rd_valid, b.overflow, b.underflow}); end
        tests++; if (b.count !== 6'd0) begin fails++; $display("FAIL reset_count_b got %0d exp 0", b.count); end
        tests++; if (b.rd_data !== 16'h0) begin fails++; $display("FAIL reset_rd_data_b got %h exp 0000", b.rd_data); end
        @(negedge clk) reset_n = 1'b1;
        cyc;
    endtask

    task automatic test_fill_drain;
        for (int i = 1; i <= 5; i++) begin
            a.wr_en = 1'b1; a.wr_data = 16'(i);
            cyc;
            tests++; if (a.count !== 3'(i)) begin fails++; $display("FAIL fill_count got %0d exp %0d", a.count, i); end
        end
        a.wr_en = 1'b0;
        tests++; if ({a.full, a.almost_full, a.empty} !== 3'b110) begin fails++; $display("FAIL fill_flags got %b exp 110", {a.full, a.almost_full, a.empty}); end
        for (int i = 1; i <= 5; i++) begin
            tests++; if (a.rd_data !== 16'(i)) begin fails++; $display("FAIL drain_data got %h exp %h", a.rd_data, 16'(i)); end
            a.rd_en = 1'b1;
            cyc;
        end
        a.rd_en = 1'b0;
        tests++; if ({a.empty, a.almost_empty, a.count} !== {2'b11, 3'd0}) begin fails++; $display("FAIL drain_empty got %b exp 11000", {a.empty, a.almost_empty, a.count}); end
        for (int i = 0; i < 3; i++) begin
            a.wr_en = 1'b1; a.wr_data = 16'h10 + 16'(i);
            cyc;
        end
        for (int k = 0; k < 9; k++) begin
            tests++; if (a.rd_data !== 16'h10 + 16'(k)) begin fails++; $display("FAIL wrap_data got %h exp %h", a.rd_data, 16'h10 + 16'(k)); end
            a.wr_en = 1'b1; a.wr_data = 16'h13 + 16'(k); a.rd_en = 1'b1;
            cyc;
            tests++; if (a.count !== 3'd3) begin fails++; $display("FAIL wrap_count got %0d exp 3", a.count); end
        end
        a.wr_en = 1'b0;
        for (int k = 9; k < 12; k++) begin
            tests++; if (a.rd_data !== 16'h10 + 16'(k)) begin fails++; $display("FAIL wrap_tail got %h exp %h", a.rd_data, 16'h10 + 16'(k)); end
            a.rd_en = 1'b1;
            cyc;
        end
        a.rd_en = 1'b0;
        tests++; if (a.empty !== 1'b1) begin fails++; $display("FAIL wrap_empty got %b exp 1", a.empty); end
    endtask

    task automatic test_full_rw;
        logic [15:0] exp_q [5];
        exp_q = '{16'h22, 16'h23, 16'h24, 16'h25, 16'hAA};
        for (int i = 1; i <= 5; i++) begin
            a.wr_en = 1'b1; a.wr_data = 16'h20 + 16'(i);
            cyc;
        end
        tests++; if (a.full !== 1'b1) begin fails++; $display("FAIL full_set got %b exp 1", a.full); end
        a.wr_data = 16'hAA; a.rd_en = 1'b1;
        tests++; if (a.rd_data !== 16'h21) begin fails++; $display("FAIL full_head got %h exp 0021", a.rd_data); end
        cyc;
        a.rd_en = 1'b0;
        tests++; if ({a.count, a.overflow} !== {3'd5, 1'b0}) begin fails++; $display("FAIL full_rw got count %0d ovf %b exp 5 0", a.count, a.overflow); end
        tests++; if (a.rd_data !== 16'h22) begin fails++; $display("FAIL full_rw_head got %h exp 0022", a.rd_data); end
        a.wr_data = 16'hBB;
        cyc;
        a.wr_en = 1'b0;
        tests++; if ({a.count, a.overflow} !== {3'd5, 1'b1}) begin fails++; $display("FAIL overflow_set got count %0d ovf %b exp 5 1", a.count, a.overflow); end
        cyc;
        tests++; if (a.overflow !== 1'b1) begin fails++; $display("FAIL overflow_sticky got %b exp 1", a.overflow); end
        for (int i = 0; i < 5; i++) begin
            tests++; if (a.rd_data !== exp_q[i]) begin fails++; $display("FAIL full_drain got %h exp %h", a.rd_data, exp_q[i]); end
            a.rd_en = 1'b1;
            cyc;
        end
        a.rd_en = 1'b0;
    endtask

    task automatic test_underflow;
        a.rd_en = 1'b1; a.wr_en = 1'b1; a.wr_data = 16'h33;
        cyc;
        a.rd_en = 1'b0; a.wr_en = 1'b0;
        tests++; if ({a.underflow, a.count} !== {1'b1, 3'd1}) begin fails++; $display("FAIL underflow got unf %b count %0d exp 1 1", a.underflow, a.count); end
        tests++; if ({a.rd_valid, a.rd_data} !== {1'b1, 16'h33}) begin fails++; $display("FAIL underflow_data got %b %h exp 1 0033", a.rd_valid, a.rd_data); end
        a.clear = 1'b1; a.wr_en = 1'b1; a.rd_en = 1'b1; a.wr_data = 16'h44;
        cyc;
        a.clear = 1'b0; a.wr_en = 1'b0; a.rd_en = 1'b0;
        tests++; if ({a.count, a.empty, a.overflow, a.underflow} !== {3'd0, 3'b100}) begin fails++; $display("FAIL clear_a got %b exp 000100", {a.count, a.empty, a.overflow, a.underflow}); end
    endtask

    task automatic test_watermarks;
        for (int i = 0; i < 28; i++) begin
            b.wr_en = 1'b1; b.wr_data = 16'h100 + 16'(i);
            cyc;
            tests++; if (b.almost_empty !== (i + 1 <= 4)) begin fails++; $display("FAIL almost_empty at %0d got %b", i + 1, b.almost_empty); end
            tests++; if (b.almost_full !== (i + 1 >= 28)) begin fails++; $display("FAIL almost_full at %0d got %b", i + 1, b.almost_full); end
        end
        b.wr_en = 1'b0;
        tests++; if (b.rd_valid !== 1'b0) begin fails++; $display("FAIL reg_idle_valid got %b exp 0", b.rd_valid); end
        b.rd_en = 1'b1;
        cyc;
        b.rd_en = 1'b0;
        tests++; if ({b.rd_valid, b.rd_data} !== {1'b1, 16'h100}) begin fails++; $display("FAIL reg_read got %b %h exp 1 0100", b.rd_valid, b.rd_data); end
        tests++; if ({b.count, b.almost_full} !== {6'd27, 1'b0}) begin fails++; $display("FAIL reg_read_count got %0d %b exp 27 0", b.count, b.almost_full); end
        cyc;
        tests++; if ({b.rd_valid, b.rd_data} !== {1'b0, 16'h100}) begin fails++; $display("FAIL reg_hold got %b %h exp 0 0100", b.rd_valid, b.rd_data); end
    endtask

    task automatic test_overflow_clear;
        for (int i = 28; i < 33; i++) begin
            b.wr_en = 1'b1; b.wr_data = 16'h100 + 16'(i);
            cyc;
        end
        b.wr_data = 16'h1FF;
        cyc;
        b.wr_en = 1'b0;
        tests++; if ({b.full, b.overflow, b.count} !== {2'b11, 6'd32}) begin fails++; $display("FAIL b_overflow got %b exp 11100000", {b.full, b.overflow, b.count}); end
        for (int k = 1; k <= 22; k++) begin
            b.rd_en = 1'b1;
            cyc;
            tests++; if (b.rd_data !== 16'h100 + 16'(k)) begin fails++; $display("FAIL b_drain got %h exp %h", b.rd_data, 16'h100 + 16'(k)); end
        end
        b.rd_en = 1'b0;
        tests++; if (b.count !== 6'd10) begin fails++; $display("FAIL b_ten got %0d exp 10", b.count); end
        b.clear = 1'b1; b.wr_en = 1'b1; b.rd_en = 1'b1; b.wr_data = 16'h1EE;
        cyc;
        b.clear = 1'b0; b.wr_en = 1'b0; b.rd_en = 1'b0;
        tests++; if ({b.count, b.empty, b.overflow, b.underflow, b.rd_valid} !== {6'd0, 4'b1000}) begin fails++; $display("FAIL clear_b got %b exp 0000001000", {b.count, b.empty, b.overflow, b.underflow, b.rd_valid}); end
    endtask

    task automatic test_async_reset;
        a.wr_en = 1'b1; a.wr_data = 16'h51;
        cyc;
        a.wr_data = 16'h52;
        cyc;
        a.wr_data = 16'h53;
        #2 reset_n = 1'b0;
        #1;
        tests++; if ({a.count, a.empty, a.almost_empty, a.full, a.rd_valid} !== {3'd0, 4'b1100}) begin fails++; $display("FAIL async_reset got %b exp 0001100", {a.count, a.empty, a.almost_empty, a.full, a.rd_valid}); end
        a.wr_en = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        cyc;
        a.wr_en = 1'b1; a.wr_data = 16'h77;
        cyc;
        a.wr_en = 1'b0;
        tests++; if ({a.count, a.rd_data} !== {3'd1, 16'h77}) begin fails++; $display("FAIL post_reset got %0d %h exp 1 0077", a.count, a.rd_data); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        {a.clear, a.wr_en, a.rd_en, a.wr_data} = '0;
        {b.clear, b.wr_en, b.rd_en, b.wr_data} = '0;
        test_reset;
        test_fill_drain;
        test_full_rw;
        test_underflow;
        test_watermarks;
        test_overflow_clear;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
